// File: rtl/alu_md_pkg.sv
// Shared opcode constants, FSM state encoding and opcode class helpers for alu_md.
package alu_md_pkg;

  localparam logic [3:0] op_and  = 4'b0000;
  localparam logic [3:0] op_or   = 4'b0001;
  localparam logic [3:0] op_add  = 4'b0010;
  localparam logic [3:0] op_xor  = 4'b0011;
  localparam logic [3:0] op_rsvd = 4'b0100;
  localparam logic [3:0] op_not  = 4'b0101;
  localparam logic [3:0] op_sub  = 4'b0110;
  localparam logic [3:0] op_srl  = 4'b0111;
  localparam logic [3:0] op_sra  = 4'b1000;
  localparam logic [3:0] op_mul  = 4'b1001;
  localparam logic [3:0] op_mulh = 4'b1010;
  localparam logic [3:0] op_div  = 4'b1011;
  localparam logic [3:0] op_rem  = 4'b1100;
  localparam logic [3:0] op_divu = 4'b1101;
  localparam logic [3:0] op_remu = 4'b1110;
  localparam logic [3:0] op_sll  = 4'b1111;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_mul  = 2'd1,
    st_div  = 2'd2,
    st_done = 2'd3
  } state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == op_mul) || (op == op_mulh);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == op_div) || (op == op_rem) || (op == op_divu) || (op == op_remu);
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per cycle for WIDTH cycles.
// Signed forms run on magnitudes; signs are re-applied on the final combinational result.
module alu_md_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res
);

  localparam logic [SHW-1:0] cnt_last = SHW'(WIDTH - 1);

  logic [WIDTH:0]   acc, acc_n, mul_add, sum, shifted, trial;
  logic [WIDTH-1:0] sreg, sreg_n, opnd, a_mag, b_mag, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic [SHW-1:0]   cnt;
  logic             active, div_mode, want_hi, want_rem, neg_q, neg_r, dz;
  logic             sgn, a_neg, b_neg;

  always_comb begin
    sgn   = is_div_op(op) ? ((op == op_div) || (op == op_rem)) : (op == op_mulh);
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration step; in mul mode {acc,sreg} is the shifting product,
  // in div mode acc is the partial remainder and sreg shifts dividend out / quotient in.
  always_comb begin
    mul_add = sreg[0] ? {1'b0, opnd} : '0;
    sum     = acc + mul_add;
    shifted = {acc[WIDTH-1:0], sreg[WIDTH-1]};
    trial   = shifted - {1'b0, opnd};
    if (div_mode) begin
      acc_n  = trial[WIDTH] ? shifted : trial;
      sreg_n = {sreg[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      acc_n  = {1'b0, sum[WIDTH:1]};
      sreg_n = {sum[0], sreg[WIDTH-1:1]};
    end
    prod = {acc_n[WIDTH-1:0], sreg_n};
    if (neg_q) prod = -prod;
    quo = dz ? '1 : (neg_q ? -sreg_n : sreg_n);
    rem = neg_r ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
    if (div_mode) res = want_rem ? rem : quo;
    else          res = want_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
  end

  assign last = active && (cnt == cnt_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0; sreg <= '0; opnd <= '0; cnt <= '0;
      active <= 1'b0; div_mode <= 1'b0; want_hi <= 1'b0; want_rem <= 1'b0;
      neg_q <= 1'b0; neg_r <= 1'b0; dz <= 1'b0;
    end else if (start) begin
      acc      <= '0;
      sreg     <= a_mag;
      opnd     <= b_mag;
      cnt      <= '0;
      active   <= 1'b1;
      div_mode <= is_div_op(op);
      want_hi  <= (op == op_mulh);
      want_rem <= (op == op_rem) || (op == op_remu);
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      dz       <= (b == '0);
    end else if (active) begin
      acc  <= acc_n;
      sreg <= sreg_n;
      cnt  <= cnt + 1'b1;
      if (last) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_md.sv
// ALU with single-cycle logic/arith/shift ops and iterative multiply/divide.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       AluControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output state_e           state_dbg
);

  state_e           state, state_n;
  logic [WIDTH-1:0] alu_res, iter_res;
  logic [SHW-1:0]   shamt;
  logic             accept, multi, iter_start, iter_last;

  assign in_ready   = (state == st_idle);
  assign out_valid  = (state == st_done);
  assign busy       = (state != st_idle);
  assign state_dbg  = state;
  assign accept     = in_valid && in_ready;
  assign multi      = is_mul_op(AluControl) || is_div_op(AluControl);
  assign iter_start = accept && multi;
  assign shamt      = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (AluControl)
      op_and:  alu_res = a & b;
      op_or:   alu_res = a | b;
      op_add:  alu_res = a + b;
      op_xor:  alu_res = a ^ b;
      op_not:  alu_res = ~a;
      op_sub:  alu_res = a - b;
      op_srl:  alu_res = a >> shamt;
      op_sra:  alu_res = $unsigned($signed(a) >>> shamt);
      op_sll:  alu_res = a << shamt;
      default: alu_res = '0;
    endcase
  end

  alu_md_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iter_start),
    .op    (AluControl),
    .a     (a),
    .b     (b),
    .last  (iter_last),
    .res   (iter_res)
  );

  always_comb begin
    state_n = state;
    case (state)
      st_idle: begin
        if (accept) begin
          if (is_mul_op(AluControl))      state_n = st_mul;
          else if (is_div_op(AluControl)) state_n = st_div;
          else                            state_n = st_done;
        end
      end
      st_mul, st_div: if (iter_last) state_n = st_done;
      st_done:        if (out_ready) state_n = st_idle;
      default:        state_n = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= st_idle;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && !multi) begin
        result <= alu_res;
        zero   <= (alu_res == '0);
      end else if (busy && !out_valid && iter_last) begin
        result <= iter_res;
        zero   <= (iter_res == '0);
      end
    end
  end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; SHALL be a power of two, at least 8.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width; only b[SHW-1:0] SHALL be used for shifts.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 AluControl  input  4  operation code, sampled on accept.
REQ-008 a, b  input  WIDTH each  operands, sampled on accept.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 zero  output  1  registered flag, high when result equals 0.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Accept SHALL occur on a cycle with in_valid and in_ready both high.
REQ-015 in_ready SHALL equal (state == IDLE).
REQ-016 Opcode map:
- 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0101 NOT a; 0110 SUB
- 0111 SRL; 1000 SRA (signed, sign-filled); 1111 SLL
- 1001 MUL (low WIDTH bits); 1010 MULH (signed x signed, high WIDTH bits)
- 1011 DIV (signed); 1100 REM (signed); 1101 DIVU; 1110 REMU
- 0100 reserved, result 0
REQ-017 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH; no carry or overflow output exists.
REQ-018 State machine: IDLE, MUL, DIV, DONE.
- IDLE -> DONE on accept of a single-cycle opcode.
- IDLE -> MUL on accept of 1001/1010.
- IDLE -> DIV on accept of 1011-1110.
REQ-019 Single-cycle opcodes SHALL raise out_valid on the cycle after accept (latency 1).
REQ-020 MUL state SHALL be a shift-add iteration of exactly WIDTH cycles, then -> DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-021 Signed MULH SHALL multiply operand magnitudes and conditionally negate the 2*WIDTH product.
REQ-022 DIV state SHALL be a restoring divide of exactly WIDTH cycles, then -> DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-023 Signed quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero: quotient all-ones; remainder = a; latency unchanged.
REQ-025 Signed overflow (a = most-negative value, b = -1): quotient = a, remainder = 0.
REQ-026 DONE: out_valid high; result and zero held stable until out_ready is high, then -> IDLE.
REQ-027 in_valid SHALL be ignored while in_ready is low; no request queuing.

Reset
REQ-028 rst_n low at a rising edge SHALL:
- force state IDLE;
- clear out_valid, busy, result and zero;
- clear all iteration counters and registers.
REQ-029 Reset during MUL, DIV or DONE SHALL abort the operation with no result delivered; in_ready SHALL be high on the first cycle after rst_n returns high.

Structure
REQ-030 Package alu_md_pkg SHALL hold the opcode constants and the state enumeration.
REQ-031 The iterative multiply/divide datapath (accumulator, shift register, counter) SHALL be one sub-module, alu_md_iter; single-cycle operations SHALL stay in alu_md.

Verification (WIDTH=32)
REQ-032 ADD a=7, b=5 -> out_valid 1 cycle after accept, result 12, zero 0; SUB 5-5 -> result 0, zero 1.
REQ-033 SRA a=0x80000000, b=4 -> 0xF8000000; SLL a=1, b=33 -> 0x00000002 (shift amount b[4:0]=1).
REQ-034 Multiply cases, out_valid exactly 33 cycles after accept:
- MUL a=0xFFFFFFFF, b=2 -> 0xFFFFFFFE
- MULH same operands -> 0xFFFFFFFF
REQ-035 Divide cases:
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF
- DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 5
- DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0
REQ-036 out_ready low 5 cycles after ADD completes -> result stable, in_ready low, concurrent in_valid not accepted; out_ready high -> IDLE on the next cycle.
REQ-037 rst_n low on the 10th cycle of DIV -> out_valid 0 and in_ready 1 afterwards; a following ADD 1+1 returns 2.
